// File: rtl/multiport_regfile_pkg.sv
// multiport_regfile_pkg: shared state type and index-width helper for the register file
package multiport_regfile_pkg;
  typedef enum logic {RF_IDLE, RF_CLEAR} regfile_state_e;
  function automatic int rf_idxw(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/multiport_regfile_write_arbiter.sv
// rf_write_arbiter: picks the highest-numbered enabled writer targeting one index
module rf_write_arbiter #(
  parameter int WIDTH = 32,
  parameter int IDXW = 4,
  parameter int NUM_WR = 2
) (
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*IDXW-1:0]  wr_idx,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic [IDXW-1:0]         idx,
  output logic                    hit,
  output logic [WIDTH-1:0]        data
);
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int p = 0; p < NUM_WR; p++)
      if (wr_en[p] && wr_idx[p*IDXW +: IDXW] == idx) begin
        hit = 1'b1;
        data = wr_data[p*WIDTH +: WIDTH];
      end
  end
endmodule

// File: rtl/multiport_regfile.sv
// multiport_regfile: N-read/M-write register array with priority writes, optional bypass
// and a sequenced clear sweep that replaces per-bit reset of the storage.
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  localparam int IDXW = rf_idxw(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_req,
  output logic                    ready,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*IDXW-1:0]  wr_idx,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  output logic                    wr_conflict,
  input  logic [NUM_RD*IDXW-1:0]  rd_idx,
  output logic [NUM_RD*WIDTH-1:0] rd_data
);
  regfile_state_e state, state_nx;
  logic [IDXW-1:0] clr_ptr, clr_ptr_nx;
  logic collide, conflict_nx, last;
  logic [DEPTH-1:0] cm_hit;
  logic [WIDTH-1:0] cm_data [DEPTH];
  (* ramstyle = "logic" *) logic [WIDTH-1:0] mem [DEPTH];

  assign ready = state == RF_IDLE;
  assign last = clr_ptr == IDXW'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RF_CLEAR;
      clr_ptr <= '0;
      wr_conflict <= 1'b0;
    end else begin
      state <= state_nx;
      clr_ptr <= clr_ptr_nx;
      wr_conflict <= conflict_nx;
    end

  always_comb begin
    state_nx = state;
    clr_ptr_nx = clr_ptr;
    if (clear_req) begin
      state_nx = RF_CLEAR;
      clr_ptr_nx = '0;
    end else if (state == RF_CLEAR) begin
      state_nx = last ? RF_IDLE : RF_CLEAR;
      clr_ptr_nx = last ? '0 : clr_ptr + IDXW'(1);
    end
  end

  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wr_en[i] && wr_en[j] && wr_idx[i*IDXW +: IDXW] == wr_idx[j*IDXW +: IDXW])
          collide = 1'b1;
  end

  // a collision in the cycle that launches a sweep is not reported, so the flag stays 0 while not ready
  assign conflict_nx = ready && !clear_req && collide;

  for (genvar e = 0; e < DEPTH; e++) begin : g_commit
    rf_write_arbiter #(.WIDTH(WIDTH), .IDXW(IDXW), .NUM_WR(NUM_WR)) u_arb (
      .wr_en(wr_en),
      .wr_idx(wr_idx),
      .wr_data(wr_data),
      .idx(IDXW'(e)),
      .hit(cm_hit[e]),
      .data(cm_data[e])
    );
  end

  always_ff @(posedge clk)
    for (int e = 0; e < DEPTH; e++)
      if (state == RF_CLEAR ? clr_ptr == IDXW'(e) : cm_hit[e])
        mem[e] <= state == RF_CLEAR ? '0 : cm_data[e];

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic hit;
    logic [WIDTH-1:0] data;
    rf_write_arbiter #(.WIDTH(WIDTH), .IDXW(IDXW), .NUM_WR(NUM_WR)) u_arb (
      .wr_en(wr_en),
      .wr_idx(wr_idx),
      .wr_data(wr_data),
      .idx(rd_idx[r*IDXW +: IDXW]),
      .hit(hit),
      .data(data)
    );
    assign rd_data[r*WIDTH +: WIDTH] = !ready ? '0 :
                                       (BYPASS != 0 && hit) ? data : mem[rd_idx[r*IDXW +: IDXW]];
  end
endmodule

// File: tb/tb_multiport_regfile.sv
// tb_multiport_regfile: randomized and directed checks of the register file against a
// cycle-level reference model (countdown for the sweep, plain array for contents).
module tb_multiport_regfile;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, c_rst_n;
  logic a_clr, a_ready, a_conf;
  logic [1:0] a_wen;
  logic [7:0] a_widx, a_ridx;
  logic [63:0] a_wdata, a_rdata;
  logic b_clr, b_ready, b_conf;
  logic [1:0] b_wen;
  logic [7:0] b_widx, b_ridx;
  logic [63:0] b_wdata, b_rdata;
  logic c_clr, c_ready, c_conf;
  logic [2:0] c_wen;
  logic [14:0] c_widx;
  logic [95:0] c_wdata;
  logic [19:0] c_ridx;
  logic [127:0] c_rdata;

  int total = 0;
  int pass_cnt = 0;

  multiport_regfile dut_a (
    .clk(clk), .rst_n(rst_n), .clear_req(a_clr), .ready(a_ready),
    .wr_en(a_wen), .wr_idx(a_widx), .wr_data(a_wdata), .wr_conflict(a_conf),
    .rd_idx(a_ridx), .rd_data(a_rdata)
  );

  multiport_regfile #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_req(b_clr), .ready(b_ready),
    .wr_en(b_wen), .wr_idx(b_widx), .wr_data(b_wdata), .wr_conflict(b_conf),
    .rd_idx(b_ridx), .rd_data(b_rdata)
  );

  multiport_regfile #(.DEPTH(32), .NUM_RD(4), .NUM_WR(3)) dut_c (
    .clk(clk), .rst_n(c_rst_n), .clear_req(c_clr), .ready(c_ready),
    .wr_en(c_wen), .wr_idx(c_widx), .wr_data(c_wdata), .wr_conflict(c_conf),
    .rd_idx(c_ridx), .rd_data(c_rdata)
  );

  // reference model of dut_a: busy = cycles left until usable
  logic [31:0] m [16];
  int busy;
  logic exp_conf;

  function automatic logic [31:0] exp_rd(input int r);
    logic [31:0] v;
    if (busy != 0) return '0;
    v = m[a_ridx[r*4 +: 4]];
    for (int p = 0; p < 2; p++)
      if (a_wen[p] && a_widx[p*4 +: 4] == a_ridx[r*4 +: 4]) v = a_wdata[p*32 +: 32];
    return v;
  endfunction

  task automatic tick();
    logic [31:0] nm [16];
    int nb;
    logic nc;
    nb = busy;
    nc = 1'b0;
    nm = m;
    if (!rst_n) nb = 16;
    else if (busy == 0) begin
      for (int p = 0; p < 2; p++) if (a_wen[p]) nm[a_widx[p*4 +: 4]] = a_wdata[p*32 +: 32];
      nc = a_wen == 2'b11 && a_widx[3:0] == a_widx[7:4];
      if (a_clr) begin
        nb = 16;
        nc = 1'b0;
      end
    end else nb = a_clr ? 16 : busy - 1;
    if (nb == 16) for (int i = 0; i < 16; i++) nm[i] = '0;
    @(posedge clk);
    #1;
    busy = nb;
    m = nm;
    exp_conf = nc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    c_rst_n = 1'b0;
    busy = 16;
    exp_conf = 1'b0;
    repeat (3) tick();
    total++;
    if (a_ready !== 1'b0 || a_conf !== 1'b0) $display("FAIL reset_state ready=%b conflict=%b want 0 0", a_ready, a_conf);
    else pass_cnt++;
    rst_n = 1'b1;
    c_rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (a_ready !== 1'b0) $display("FAIL sweep_ready cycle %0d got %b want 0", i, a_ready);
      else pass_cnt++;
      tick();
    end
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) $display("FAIL sweep_done ready a=%b b=%b want 1 1", a_ready, b_ready);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      a_ridx = {4'(2*i+1), 4'(2*i)};
      #1;
      total++;
      if (a_rdata !== 64'd0) $display("FAIL reset_zero entries %0d,%0d got %h want 0", 2*i, 2*i+1, a_rdata);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_write();
    a_wen = 2'b01;
    a_widx = {4'd0, 4'd3};
    a_wdata = {32'd0, 32'hDEADBEEF};
    a_ridx = {4'd0, 4'd3};
    #1;
    total++;
    if (a_rdata[31:0] !== 32'hDEADBEEF) $display("FAIL single_bypass got %h want deadbeef", a_rdata[31:0]);
    else pass_cnt++;
    tick();
    a_wen = 2'b00;
    #1;
    total++;
    if (a_rdata[31:0] !== 32'hDEADBEEF || a_conf !== 1'b0)
      $display("FAIL single_stored got %h conflict=%b want deadbeef 0", a_rdata[31:0], a_conf);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    a_wen = 2'b11;
    a_widx = {4'd5, 4'd5};
    a_wdata = {32'h22, 32'h11};
    a_ridx = {4'd5, 4'd5};
    #1;
    total++;
    if (a_rdata[63:32] !== 32'h22) $display("FAIL collide_bypass got %h want 22", a_rdata[63:32]);
    else pass_cnt++;
    tick();
    a_wen = 2'b00;
    #1;
    total++;
    if (a_conf !== 1'b1 || a_rdata[31:0] !== 32'h22)
      $display("FAIL collide_commit conflict=%b data=%h want 1 22", a_conf, a_rdata[31:0]);
    else pass_cnt++;
    tick();
    total++;
    if (a_conf !== 1'b0) $display("FAIL collide_pulse conflict=%b want 0", a_conf);
    else pass_cnt++;
  endtask

  task automatic test_bypass_off();
    b_wen = 2'b01;
    b_widx = {4'd0, 4'd7};
    b_wdata = {32'd0, 32'hA5};
    b_ridx = {4'd0, 4'd7};
    #1;
    total++;
    if (b_rdata[31:0] !== 32'd0) $display("FAIL nobypass_same got %h want 0", b_rdata[31:0]);
    else pass_cnt++;
    tick();
    b_wen = 2'b00;
    #1;
    total++;
    if (b_rdata[31:0] !== 32'hA5) $display("FAIL nobypass_next got %h want a5", b_rdata[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int guard;
    for (int n = 0; n < 300; n++) begin
      a_wen = 2'($urandom);
      a_widx = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a_widx[7:4] = a_widx[3:0];
      a_wdata = {$urandom, $urandom};
      a_ridx = (n % 4 == 0) ? a_widx : 8'($urandom);
      a_clr = $urandom_range(0, 59) == 0;
      #1;
      total++;
      if (a_ready !== (busy == 0)) $display("FAIL rand_ready n=%0d got %b want %b", n, a_ready, busy == 0);
      else pass_cnt++;
      total++;
      if (a_conf !== exp_conf) $display("FAIL rand_conflict n=%0d got %b want %b", n, a_conf, exp_conf);
      else pass_cnt++;
      for (int r = 0; r < 2; r++) begin
        total++;
        if (a_rdata[r*32 +: 32] !== exp_rd(r))
          $display("FAIL rand_read n=%0d port %0d got %h want %h", n, r, a_rdata[r*32 +: 32], exp_rd(r));
        else pass_cnt++;
      end
      tick();
    end
    a_clr = 1'b0;
    a_wen = 2'b00;
    guard = 0;
    while (busy != 0 && guard < 40) begin
      tick();
      guard++;
    end
  endtask

  task automatic test_clear_req();
    int cyc;
    for (int i = 0; i < 8; i++) begin
      a_wen = 2'b11;
      a_widx = {4'(2*i+1), 4'(2*i)};
      a_wdata = {$urandom, $urandom};
      tick();
    end
    a_wen = 2'b00;
    for (int i = 0; i < 8; i++) begin
      a_ridx = {4'(2*i+1), 4'(2*i)};
      #1;
      total++;
      if (a_rdata !== {exp_rd(1), exp_rd(0)}) $display("FAIL fill_read entry %0d got %h want %h", 2*i, a_rdata, {exp_rd(1), exp_rd(0)});
      else pass_cnt++;
    end
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    for (int k = 0; k < 9; k++) begin
      a_wen = 2'b11;
      a_widx = 8'($urandom);
      a_wdata = {$urandom, $urandom};
      a_ridx = a_widx;
      #1;
      total++;
      if (a_ready !== 1'b0 || a_rdata !== 64'd0) $display("FAIL sweep_masked k=%0d ready=%b data=%h want 0 0", k, a_ready, a_rdata);
      else pass_cnt++;
      tick();
    end
    a_wen = 2'b00;
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    cyc = 0;
    while (a_ready !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc != 16) $display("FAIL restart_len got %0d cycles want 16", cyc);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      a_ridx = {4'(2*i+1), 4'(2*i)};
      #1;
      total++;
      if (a_rdata !== 64'd0) $display("FAIL clear_zero entry %0d got %h want 0", 2*i, a_rdata);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    total++;
    if (c_ready !== 1'b1) $display("FAIL wide_ready got %b want 1", c_ready);
    else pass_cnt++;
    c_wen = 3'b100;
    c_widx = {5'd4, 10'd0};
    c_wdata = {32'h1234, 64'd0};
    tick();
    c_wen = 3'b000;
    c_ridx = {15'd0, 5'd4};
    #1;
    total++;
    if (c_rdata[31:0] !== 32'h1234) $display("FAIL wide_write got %h want 1234", c_rdata[31:0]);
    else pass_cnt++;
    #2 c_rst_n = 1'b0;
    #1;
    total++;
    if (c_ready !== 1'b0 || c_rdata !== 128'd0) $display("FAIL wide_async ready=%b data=%h want 0 0", c_ready, c_rdata);
    else pass_cnt++;
    repeat (2) tick();
    c_rst_n = 1'b1;
    cyc = 0;
    while (c_ready !== 1'b1 && cyc < 80) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc != 32) $display("FAIL wide_sweep got %0d cycles want 32", cyc);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      c_ridx = {5'(4*i+3), 5'(4*i+2), 5'(4*i+1), 5'(4*i)};
      #1;
      total++;
      if (c_rdata !== 128'd0) $display("FAIL wide_zero entries from %0d got %h want 0", 4*i, c_rdata);
      else pass_cnt++;
    end
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    repeat (6) tick();
    #2 rst_n = 1'b0;
    busy = 16;
    exp_conf = 1'b0;
    #1;
    total++;
    if (a_ready !== 1'b0 || a_conf !== 1'b0) $display("FAIL async_mid ready=%b conflict=%b want 0 0", a_ready, a_conf);
    else pass_cnt++;
    repeat (2) tick();
    rst_n = 1'b1;
    cyc = 0;
    while (a_ready !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc != 16) $display("FAIL async_sweep got %0d cycles want 16", cyc);
    else pass_cnt++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    {a_clr, a_wen, a_widx, a_wdata, a_ridx} = '0;
    {b_clr, b_wen, b_widx, b_wdata, b_ridx} = '0;
    {c_clr, c_wen, c_widx, c_wdata, c_ridx} = '0;
    rst_n = 1'b0;
    c_rst_n = 1'b0;
    for (int i = 0; i < 16; i++) m[i] = '0;
    busy = 16;
    exp_conf = 1'b0;
    test_reset();
    test_single_write();
    test_collision();
    test_bypass_off();
    test_random();
    test_clear_req();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
